// File: rtl/dfi_phase_ctrl_if.sv
// DFI ownership sequencer bundle: PHY init handshake, engine
// start/done pairs, transaction grant and recalibration request.
interface dfi_phase_ctrl_if;
    logic       dfi_init_start;
    logic       dfi_init_complete;
    logic       init_start;
    logic       init_done;
    logic       cali_start;
    logic       cali_done;
    logic       tran_grant;
    logic       tran_idle;
    logic       recal_req;
    logic       recal_ack;
    logic [1:0] sel;
    logic       ready;
    logic       timeout_err;

    modport master (
        output dfi_init_start,
        output init_start,
        output cali_start,
        output tran_grant,
        output recal_ack,
        output sel,
        output ready,
        output timeout_err,
        input  dfi_init_complete,
        input  init_done,
        input  cali_done,
        input  tran_idle,
        input  recal_req
    );

    modport slave (
        input  dfi_init_start,
        input  init_start,
        input  cali_start,
        input  tran_grant,
        input  recal_ack,
        input  sel,
        input  ready,
        input  timeout_err,
        output dfi_init_complete,
        output init_done,
        output cali_done,
        output tran_idle,
        output recal_req
    );
endinterface

// File: rtl/dfi_phase_ctrl.sv
// Hands the shared DFI bus from PHY/DRAM init to calibration to the
// transaction engine, with idle gaps between owners and run-time recal.
module dfi_phase_ctrl #(
    parameter int unsigned SWITCH_GAP = 4,
    parameter int unsigned TIMEOUT_W  = 16,
    parameter int unsigned TIMEOUT    = 16'hFFFF
) (
    input logic            clk,
    input logic            rst_n,
    dfi_phase_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        PHY_INIT,
        INIT,
        CALI,
        TRAN,
        DRAIN,
        GAP
    } state_t;

    localparam logic [3:0] GAP_LD = 4'(SWITCH_GAP - 1);
    localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] WD_MAX = {TIMEOUT_W{1'b1}};
    localparam bit WD_EN = (TIMEOUT != 0);

    state_t state, nstate;
    state_t tgt, ntgt;
    logic [3:0] gcnt, ngcnt;
    logic [TIMEOUT_W-1:0] wd, nwd;
    logic recal, nrecal;
    logic waiting;
    logic stay_wait;
    logic ack_d;
    logic err_d;
    logic [1:0] sel_d;

    logic [1:0] sel_q;
    logic dis_q;
    logic ist_q;
    logic cst_q;
    logic gr_q;
    logic ack_q;
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PHY_INIT;
            tgt   <= INIT;
            gcnt  <= '0;
            wd    <= '0;
            recal <= 1'b0;
        end else begin
            state <= nstate;
            tgt   <= ntgt;
            gcnt  <= ngcnt;
            wd    <= nwd;
            recal <= nrecal;
        end
    end

    always_comb begin
        nstate = state;
        ntgt   = tgt;
        ngcnt  = gcnt;
        nrecal = recal;
        ack_d  = 1'b0;
        unique case (state)
            PHY_INIT: begin
                // only a request the PHY has actually seen may complete
                if (dis_q && bus.dfi_init_complete) begin
                    nstate = GAP;
                    ntgt   = INIT;
                end
            end
            INIT: begin
                if (!ist_q && bus.init_done) begin
                    nstate = GAP;
                    ntgt   = CALI;
                end
            end
            CALI: begin
                if (bus.cali_done) begin
                    nstate = GAP;
                    ntgt   = TRAN;
                    ack_d  = recal;
                    nrecal = 1'b0;
                end
            end
            TRAN: begin
                if (bus.recal_req) begin
                    nstate = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.tran_idle) begin
                    nstate = GAP;
                    ntgt   = CALI;
                    nrecal = 1'b1;
                end
            end
            GAP: begin
                if (gcnt == 4'd0) begin
                    nstate = tgt;
                end else begin
                    ngcnt = gcnt - 4'd1;
                end
            end
            default: begin
                nstate = PHY_INIT;
            end
        endcase
        if (nstate == GAP && state != GAP) begin
            ngcnt = GAP_LD;
        end
    end

    always_comb begin
        waiting = 1'b0;
        unique case (state)
            PHY_INIT, INIT, CALI, DRAIN: waiting = 1'b1;
            default:                     waiting = 1'b0;
        endcase
        stay_wait = waiting && (nstate == state);
        nwd = '0;
        if (stay_wait) begin
            nwd = (wd == WD_MAX) ? wd : wd + TIMEOUT_W'(1);
        end
        err_d = err_q || (WD_EN && stay_wait && nwd >= TO_LIM);
    end

    always_comb begin
        sel_d = 2'd3;
        unique case (nstate)
            INIT:        sel_d = 2'd0;
            CALI:        sel_d = 2'd1;
            TRAN, DRAIN: sel_d = 2'd2;
            default:     sel_d = 2'd3;
        endcase
    end

    // outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 2'd3;
            dis_q <= 1'b0;
            ist_q <= 1'b0;
            cst_q <= 1'b0;
            gr_q  <= 1'b0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            dis_q <= (nstate == PHY_INIT);
            ist_q <= (nstate == INIT) && (state != INIT);
            cst_q <= (nstate == CALI) && (state != CALI);
            gr_q  <= (nstate == TRAN);
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    assign bus.sel            = sel_q;
    assign bus.dfi_init_start = dis_q;
    assign bus.init_start     = ist_q;
    assign bus.cali_start     = cst_q;
    assign bus.tran_grant     = gr_q;
    assign bus.ready          = gr_q;
    assign bus.recal_ack      = ack_q;
    assign bus.timeout_err    = err_q;

endmodule

// File: tb/tb_dfi_phase_ctrl.sv
// Timeline bench: each run is laid out as phases of known length and
// every cycle's outputs are compared against that expected trace.
module tb_dfi_phase_ctrl;

    typedef struct {
        logic       dic;
        logic       idn;
        logic       cdn;
        logic       idl;
        logic       rrq;
        logic [1:0] sel;
        logic       dis;
        logic       ist;
        logic       cst;
        logic       gr;
        logic       ack;
        logic       err;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic dic = 1'b0;
    logic idn = 1'b0;
    logic cdn = 1'b0;
    logic idl = 1'b0;
    logic rrq = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    cyc_t q[$];
    int g = 4;
    int to_lim = 100;
    bit err_m;
    bit rq;
    bit use_b;

    always #5 clk = ~clk;

    dfi_phase_ctrl_if ifa ();
    dfi_phase_ctrl_if ifb ();

    assign ifa.dfi_init_complete = dic;
    assign ifa.init_done         = idn;
    assign ifa.cali_done         = cdn;
    assign ifa.tran_idle         = idl;
    assign ifa.recal_req         = rrq;
    assign ifb.dfi_init_complete = dic;
    assign ifb.init_done         = idn;
    assign ifb.cali_done         = cdn;
    assign ifb.tran_idle         = idl;
    assign ifb.recal_req         = rrq;

    dfi_phase_ctrl #(
        .SWITCH_GAP(4),
        .TIMEOUT_W (16),
        .TIMEOUT   (100)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_a),
        .bus  (ifa)
    );

    dfi_phase_ctrl #(
        .SWITCH_GAP(1),
        .TIMEOUT_W (16),
        .TIMEOUT   (0)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_b),
        .bus  (ifb)
    );

    function automatic logic [8:0] obs();
        if (use_b)
            return {ifb.sel, ifb.dfi_init_start, ifb.init_start,
                    ifb.cali_start, ifb.tran_grant, ifb.ready,
                    ifb.recal_ack, ifb.timeout_err};
        return {ifa.sel, ifa.dfi_init_start, ifa.init_start,
                ifa.cali_start, ifa.tran_grant, ifa.ready,
                ifa.recal_ack, ifa.timeout_err};
    endfunction

    task automatic chk(input string tag, input int c,
                       input logic [8:0] e);
        logic [8:0] o;
        o = obs();
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cyc %0d: observed %b expected %b",
                   tag, c, o, e);
        end
    endtask

    function automatic cyc_t base();
        cyc_t x;
        x.dic = 1'($urandom_range(0, 1));
        x.idn = 1'($urandom_range(0, 1));
        x.cdn = 1'($urandom_range(0, 1));
        x.idl = 1'($urandom_range(0, 1));
        x.rrq = 1'b0;
        x.sel = 2'd3;
        x.dis = 1'b0;
        x.ist = 1'b0;
        x.cst = 1'b0;
        x.gr  = 1'b0;
        x.ack = 1'b0;
        x.err = 1'b0;
        return x;
    endfunction

    // k is the number of cycles already spent waiting in this phase
    task automatic push(input cyc_t x, input bit wt, input int k);
        if (wt && to_lim != 0 && k >= to_lim) err_m = 1'b1;
        x.err = err_m;
        x.rrq = rq;
        q.push_back(x);
    endtask

    task automatic ph_phy(input int p);
        cyc_t x;
        for (int j = 1; j <= p; j++) begin
            x = base();
            x.dis = 1'b1;
            x.dic = (j == p);
            push(x, 1'b1, j);
        end
    endtask

    task automatic ph_gap(input bit a);
        cyc_t x;
        for (int j = 1; j <= g; j++) begin
            x = base();
            x.ack = a && (j == 1);
            push(x, 1'b0, 0);
            if (x.ack) rq = 1'b0;
        end
    endtask

    task automatic ph_init(input int n);
        cyc_t x;
        for (int j = 1; j <= n; j++) begin
            x = base();
            x.sel = 2'd0;
            x.ist = (j == 1);
            if (j > 1) x.idn = (j == n);
            push(x, 1'b1, j - 1);
        end
    endtask

    task automatic ph_cali(input int n);
        cyc_t x;
        for (int j = 1; j <= n; j++) begin
            x = base();
            x.sel = 2'd1;
            x.cst = (j == 1);
            x.cdn = (j == n);
            push(x, 1'b1, j - 1);
        end
    endtask

    task automatic ph_tran(input int n, input bit r);
        cyc_t x;
        for (int j = 1; j <= n; j++) begin
            x = base();
            x.sel = 2'd2;
            x.gr  = 1'b1;
            if (r && j == n) rq = 1'b1;
            push(x, 1'b0, 0);
        end
    endtask

    task automatic ph_drain(input int n);
        cyc_t x;
        for (int j = 1; j <= n; j++) begin
            x = base();
            x.sel = 2'd2;
            x.idl = (j == n);
            push(x, 1'b1, j - 1);
        end
    endtask

    task automatic build(input int p, input int i, input int c,
                         input int t1, input int d, input int c2,
                         input int t2, input bit early);
        q.delete();
        err_m = 1'b0;
        rq = early;
        ph_phy(p);
        ph_gap(1'b0);
        ph_init(i);
        ph_gap(1'b0);
        ph_cali(c);
        ph_gap(1'b0);
        ph_tran(t1, 1'b1);
        ph_drain(d);
        ph_gap(1'b0);
        ph_cali(c2);
        ph_gap(1'b1);
        ph_tran(t2, 1'b0);
    endtask

    task automatic do_reset(input bit b, input bit early);
        rst_a = 1'b0;
        rst_b = 1'b0;
        dic = 1'b0;
        idn = 1'b0;
        cdn = 1'b0;
        idl = 1'b0;
        rrq = early;
        use_b = b;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", 0, {2'd3, 7'b0});
        if (b) rst_b = 1'b1;
        else   rst_a = 1'b1;
    endtask

    task automatic run(input string tag, input int n);
        for (int c = 0; c < n && c < q.size(); c++) begin
            @(posedge clk);
            #1;
            chk(tag, c + 1, {q[c].sel, q[c].dis, q[c].ist, q[c].cst,
                             q[c].gr, q[c].gr, q[c].ack, q[c].err});
            dic = q[c].dic;
            idn = q[c].idn;
            cdn = q[c].cdn;
            idl = q[c].idl;
            rrq = q[c].rrq;
        end
    endtask

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    initial begin
        g = 4;
        to_lim = 100;

        do_reset(1'b0, 1'b0);
        build(10, 20, 30, 5, 7, 4, 6, 1'b0);
        run("directed", q.size());

        for (int r = 0; r < 5; r++) begin
            do_reset(1'b0, 1'b0);
            build(rnd(1, 20), rnd(2, 25), rnd(1, 25), rnd(1, 10),
                  rnd(1, 10), rnd(1, 25), rnd(1, 8), 1'b0);
            run("random", q.size());
        end

        do_reset(1'b0, 1'b0);
        build(130, 3, 2, 2, 2, 2, 3, 1'b0);
        run("timeout", q.size());

        do_reset(1'b0, 1'b0);
        build(5, 4, 10, 3, 2, 2, 3, 1'b0);
        run("pre_abort", 5 + 4 + 4 + 4 + 4);
        #3;
        rst_a = 1'b0;
        #1;
        chk("async_rst", 0, {2'd3, 7'b0});
        do_reset(1'b0, 1'b0);
        build(rnd(1, 15), rnd(2, 15), rnd(1, 15), rnd(1, 6),
              rnd(1, 6), rnd(1, 15), 4, 1'b0);
        run("restart", q.size());

        g = 1;
        to_lim = 0;
        do_reset(1'b1, 1'b1);
        build(150, 3, 4, 1, 1, 2, 4, 1'b1);
        run("gap1_early", q.size());

        do_reset(1'b1, 1'b1);
        build(rnd(1, 10), rnd(2, 10), rnd(1, 10), 1, rnd(1, 5),
              rnd(1, 10), 3, 1'b1);
        run("gap1_rand", q.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
